// File: rtl/not16_deser_pkg.sv
// Shared constants and types for the Not16 serial receive path.
package not16_deser_pkg;

    // Word width used when a parent does not override it.
    localparam int DEFAULT_WIDTH = 16;

    // Width of the saturating framing-error counter.
    localparam int ERR_CNT_W = 8;

    // Order in which serial beats fill the restored word.
    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } bit_order_e;

endpackage

// File: rtl/not16_deser_out_reg.sv
// Single-entry valid/ready holding register for restored words.
// The raw serial word is inverted as it is loaded, so the consumer sees the
// original (non-inverted) value. A load on the same edge as a handshake
// replaces the held word without a bubble.
module not16_deser_out_reg
    import not16_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] raw,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Hold the word until it is taken; a new word may replace it on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= ~raw;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/not16_deser.sv
// Receive end of the serial inverted-word link beside the Not16 datapath.
// Collects WIDTH inverted bits, restores the word and presents it on a
// valid/ready port. Framing violations pulse frame_err and bump a
// saturating counter.
module not16_deser
    import not16_deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    input  logic                 s_bit,
    input  logic                 s_first,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [WIDTH-1:0]     m_data,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shreg;

    logic             accept;
    logic             bad_beat;
    logic             complete;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] assembled;

    // Only the final beat of a word can be stalled, and only while the
    // holding register is full and not being drained this cycle.
    assign s_ready = (count == LAST) ? !(m_valid && !m_ready) : 1'b1;

    // Decode the accepted beat: where its bit lands and what it means for framing.
    always_comb begin
        accept   = s_valid && s_ready;
        bad_beat = accept && (((state == ST_IDLE) && !s_first) ||
                              ((state == ST_SHIFT) && s_first));
        complete = accept && (state == ST_SHIFT) && !s_first && (count == LAST);
        idx      = s_first ? '0 : count;
        pos      = (bit_order_e'(MSB_FIRST) == ORDER_MSB_FIRST) ? (LAST - idx) : idx;
        mask     = WIDTH'(1) << pos;
        base     = s_first ? '0 : shreg;
        assembled = s_bit ? (base | mask) : (base & ~mask);
    end

    // Word assembly state machine; a first-bit beat always restarts the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
            shreg <= '0;
        end else if (accept) begin
            if (s_first) begin
                state <= ST_SHIFT;
                count <= CW'(1);
                shreg <= assembled;
            end else if (state == ST_SHIFT) begin
                if (count == LAST) begin
                    state <= ST_IDLE;
                    count <= '0;
                    shreg <= '0;
                end else begin
                    count <= count + CW'(1);
                    shreg <= assembled;
                end
            end
        end
    end

    // Framing error pulse and saturating violation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            frame_err <= bad_beat;
            if (bad_beat && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

    not16_deser_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (complete),
        .raw   (assembled),
        .ready (m_ready),
        .valid (m_valid),
        .data  (m_data)
    );

endmodule

// File: tb/tb_not16_deser.sv
// Directed bench for not16_deser. Two instances (LSB-first and MSB-first)
// share the same serial stimulus; the MSB-first copy must restore the
// bit-reversed word of the LSB-first copy.
module tb_not16_deser;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_bit;
    logic        s_first;
    logic        m_ready;

    logic        lsb_s_ready;
    logic        lsb_m_valid;
    logic [15:0] lsb_m_data;
    logic        lsb_frame_err;
    logic [7:0]  lsb_err_count;

    logic        msb_s_ready;
    logic        msb_m_valid;
    logic [15:0] msb_m_data;
    logic        msb_frame_err;
    logic [7:0]  msb_err_count;

    int checks = 0;
    int errors = 0;

    not16_deser #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_bit     (s_bit),
        .s_first   (s_first),
        .s_ready   (lsb_s_ready),
        .m_valid   (lsb_m_valid),
        .m_data    (lsb_m_data),
        .m_ready   (m_ready),
        .frame_err (lsb_frame_err),
        .err_count (lsb_err_count)
    );

    not16_deser #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_bit     (s_bit),
        .s_first   (s_first),
        .s_ready   (msb_s_ready),
        .m_valid   (msb_m_valid),
        .m_data    (msb_m_data),
        .m_ready   (m_ready),
        .frame_err (msb_frame_err),
        .err_count (msb_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15-i];
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock with the given serial inputs; returns 1 ns after the edge.
    task automatic beat(input logic v, input logic b, input logic f);
        s_valid = v;
        s_bit   = b;
        s_first = f;
        @(posedge clk);
        #1;
    endtask

    // Send beats first_k..last_k of ~word; order picks which word bit goes out at beat k.
    task automatic apply_stimulus(input logic [15:0] word, input logic order,
                                  input int first_k, input int last_k);
        for (int k = first_k; k <= last_k; k++) begin
            int bit_idx;
            bit_idx = order ? 15 - k : k;
            beat(1'b1, ~word[bit_idx], k == 0);
        end
    endtask

    task automatic check_word(input string tag, input logic [15:0] exp_lsb,
                              input logic [15:0] exp_msb);
        check_output({tag, "_lsb_valid"}, 32'(lsb_m_valid), 32'd1);
        check_output({tag, "_lsb_data"},  32'(lsb_m_data),  32'(exp_lsb));
        check_output({tag, "_msb_valid"}, 32'(msb_m_valid), 32'd1);
        check_output({tag, "_msb_data"},  32'(msb_m_data),  32'(exp_msb));
    endtask

    initial begin
        logic [15:0] w;

        // Reset state
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_bit   = 1'b0;
        s_first = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_m_valid",   32'(lsb_m_valid),   32'd0);
        check_output("rst_m_data",    32'(lsb_m_data),    32'd0);
        check_output("rst_frame_err", 32'(lsb_frame_err), 32'd0);
        check_output("rst_err_count", 32'(lsb_err_count), 32'd0);
        check_output("rst_s_ready",   32'(lsb_s_ready),   32'd1);
        check_output("rst_msb_valid", 32'(msb_m_valid),   32'd0);
        rst_n = 1'b1;
        beat(1'b0, 1'b0, 1'b0);

        // Word 0x00FF, LSB first, m_valid exactly after the 16th beat
        apply_stimulus(16'h00FF, 1'b0, 0, 14);
        check_output("w00ff_valid_early", 32'(lsb_m_valid), 32'd0);
        check_output("w00ff_ferr_mid",    32'(lsb_frame_err), 32'd0);
        apply_stimulus(16'h00FF, 1'b0, 15, 15);
        check_word("w00ff", 16'h00FF, 16'hFF00);
        check_output("w00ff_ferr", 32'(lsb_frame_err), 32'd0);
        beat(1'b0, 1'b0, 1'b0);
        check_output("w00ff_consumed", 32'(lsb_m_valid), 32'd0);

        // Backpressure: 0x1234 held, 0xABCD stalls on its last beat
        m_ready = 1'b0;
        apply_stimulus(16'h1234, 1'b0, 0, 15);
        check_word("bp_first", 16'h1234, rev16(16'h1234));
        apply_stimulus(16'hABCD, 1'b0, 0, 7);
        check_output("bp_partial_ready", 32'(lsb_s_ready), 32'd1);
        apply_stimulus(16'hABCD, 1'b0, 8, 14);
        s_valid = 1'b1;
        s_bit   = ~w_bit(16'hABCD, 15);
        s_first = 1'b0;
        #1;
        check_output("bp_stall_ready", 32'(lsb_s_ready), 32'd0);
        check_output("bp_stall_ready_msb", 32'(msb_s_ready), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_word("bp_hold", 16'h1234, rev16(16'h1234));
        m_ready = 1'b1;
        #1;
        check_output("bp_release_ready", 32'(lsb_s_ready), 32'd1);
        @(posedge clk);
        #1;
        check_word("bp_second", 16'hABCD, rev16(16'hABCD));
        beat(1'b0, 1'b0, 1'b0);
        check_output("bp_drained", 32'(lsb_m_valid), 32'd0);
        check_output("bp_no_ferr", 32'(lsb_err_count), 32'd0);

        // Framing errors: stray beat in IDLE, then restart at count 7
        beat(1'b1, 1'b1, 1'b0);
        check_output("fe_idle_pulse", 32'(lsb_frame_err), 32'd1);
        check_output("fe_idle_count", 32'(lsb_err_count), 32'd1);
        check_output("fe_idle_valid", 32'(lsb_m_valid),   32'd0);
        beat(1'b0, 1'b0, 1'b0);
        check_output("fe_pulse_end", 32'(lsb_frame_err), 32'd0);
        apply_stimulus(16'h0F0F, 1'b0, 0, 6);
        apply_stimulus(16'h5A5A, 1'b0, 0, 0);
        check_output("fe_restart_pulse", 32'(lsb_frame_err), 32'd1);
        check_output("fe_restart_count", 32'(lsb_err_count), 32'd2);
        check_output("fe_restart_count_msb", 32'(msb_err_count), 32'd2);
        apply_stimulus(16'h5A5A, 1'b0, 1, 15);
        check_word("fe_new_word", 16'h5A5A, rev16(16'h5A5A));
        check_output("fe_new_word_ferr", 32'(lsb_frame_err), 32'd0);
        beat(1'b0, 1'b0, 1'b0);

        // Reset mid-word while a word is also being held
        m_ready = 1'b0;
        apply_stimulus(16'hC3C3, 1'b0, 0, 15);
        check_word("rm_held", 16'hC3C3, rev16(16'hC3C3));
        apply_stimulus(16'h1111, 1'b0, 0, 8);
        rst_n = 1'b0;
        #2;
        check_output("rm_valid",     32'(lsb_m_valid),   32'd0);
        check_output("rm_err_count", 32'(lsb_err_count), 32'd0);
        check_output("rm_data",      32'(lsb_m_data),    32'd0);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        beat(1'b0, 1'b0, 1'b0);
        apply_stimulus(16'hFFFF, 1'b0, 0, 15);
        check_word("rm_ffff", 16'hFFFF, 16'hFFFF);
        check_output("rm_ffff_ferr", 32'(lsb_err_count), 32'd0);
        beat(1'b0, 1'b0, 1'b0);

        // 100 random words, MSB first order, back to back with m_ready high
        for (int n = 0; n < 100; n++) begin
            w = 16'($urandom);
            for (int k = 0; k < 16; k++) begin
                apply_stimulus(w, 1'b1, k, k);
                check_output("rnd_valid_period", 32'(msb_m_valid), 32'(k == 15));
            end
            check_output("rnd_msb_data", 32'(msb_m_data), 32'(w));
            check_output("rnd_lsb_data", 32'(lsb_m_data), 32'(rev16(w)));
        end
        check_output("rnd_no_ferr", 32'(msb_err_count), 32'd0);

        // 300 bad first beats saturate the error counter
        for (int n = 1; n <= 300; n++) begin
            beat(1'b1, 1'b0, 1'b0);
            if (n == 254) check_output("sat_254", 32'(lsb_err_count), 32'd254);
            if (n == 255) check_output("sat_255", 32'(lsb_err_count), 32'd255);
        end
        check_output("sat_count", 32'(lsb_err_count), 32'd255);
        check_output("sat_pulse", 32'(lsb_frame_err), 32'd1);
        check_output("sat_count_msb", 32'(msb_err_count), 32'd255);
        beat(1'b0, 1'b0, 1'b0);
        check_output("sat_pulse_end", 32'(lsb_frame_err), 32'd0);
        check_output("sat_hold", 32'(lsb_err_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Word bit at serial position k for LSB-first order.
    function automatic logic w_bit(input logic [15:0] word, input int k);
        return word[k];
    endfunction

endmodule

// File: doc/not16_deser.md
Name: not16_deser

Overview:
- Receive end of the serial inverted-word link used beside the Not16 datapath.
- The far end transmits ~word one bit per accepted beat.
- This block assembles WIDTH bits, re-inverts them to restore the original word, and presents it on a valid/ready output port.
- It sits between the serial link and any 16-bit consumer (ALU operand register, RAM write port).

Parameters:
- WIDTH, 16, word width in bits; legal range 2..32.
- MSB_FIRST, 0, 0 = first accepted bit lands in out bit 0; 1 = first accepted bit lands in out bit WIDTH-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  serial beat valid.
- s_bit  input  1  serial data bit, carries inverted polarity (~word).
- s_first  input  1  marks first bit of a word; meaningful only when s_valid=1.
- s_ready  output  1  block can accept the beat this cycle.
- m_valid  output  1  restored word available.
- m_data  output  WIDTH  restored word = ~(assembled serial bits).
- m_ready  input  1  consumer accepts m_data this cycle.
- frame_err  output  1  one-cycle pulse on a framing violation.
- err_count  output  8  saturating count of framing violations.

Behaviour:
- Reset (async assert, sync release): bit count=0, shift reg=0, m_valid=0, m_data=0, frame_err=0, err_count=0, state=IDLE.
- A beat is accepted when s_valid && s_ready at a rising edge.
- States:
  - IDLE: count=0, waiting for a first bit.
  - SHIFT: 1 <= count <= WIDTH-1.
- IDLE transitions:
  - Accepted beat with s_first=1: store bit at index 0, count=1, go to SHIFT.
  - Accepted beat with s_first=0: bit discarded, frame_err pulses next cycle, err_count+1, stay IDLE.
- SHIFT transitions:
  - Accepted beat with s_first=0: store bit at index count, count+1.
  - Accepted beat with s_first=1: partial word dropped, frame_err pulse, err_count+1. The bit starts a new word (index 0, count=1).
- Word completion: the accepted beat at count=WIDTH-1 with s_first=0 completes the word.
  - Next cycle: m_data = ~assembled word, m_valid=1, count=0, state IDLE.
  - Latency: last bit accepted at edge N gives m_valid=1 after edge N.
- Bit placement: index k maps to m_data[k] when MSB_FIRST=0, and to m_data[WIDTH-1-k] when MSB_FIRST=1.
- Output holding:
  - m_valid stays high and m_data is stable until m_valid && m_ready.
  - m_valid clears on that edge unless a new word completes on the same edge; then m_valid stays 1 with new data (no bubble).
- s_ready = 1, except s_ready = ~(m_valid && !m_ready) when count == WIDTH-1.
  - This is combinational from m_ready and is the only combinational input-to-output path.
  - Partial-word beats are never stalled.
- Back-to-back: with m_ready=1 continuously, one word per WIDTH cycles, no idle cycles.
- err_count saturates at 255; frame_err still pulses when saturated.
- s_bit, s_first ignored when s_valid=0. m_ready ignored when m_valid=0.
- Reset mid-word or with m_valid=1: all state cleared immediately (async). Partial and held words are lost.

Decomposition:
- Shared package holds:
  - Default WIDTH constant (16).
  - Bit-order enumeration (LSB_FIRST=0, MSB_FIRST=1).
  - Error-counter width constant (8).
- One natural sub-module: not16_deser_out_reg, the single-entry valid/ready holding register with same-edge replace.
- Bit inversion is done on the load into the holding register (reuses the Not16 primitive, WIDTH-generic).

Test Plan:
- Word 0x00FF: MSB_FIRST=0, m_ready=1, send ~0x00FF = 0xFF00 LSB first with s_first on beat 0 -> m_data=0x00FF, m_valid=1 exactly one cycle after the 16th beat; frame_err never pulses.
- Backpressure: hold m_ready=0, send 0x1234 then 0xABCD.
  - -> s_ready=0 at count 15 of the second word; m_data stays 0x1234.
  - Raise m_ready -> 0x1234 consumed, then 0xABCD presented; no bit lost.
- Framing errors:
  - Beat with s_first=0 in IDLE -> frame_err pulse, err_count=1.
  - s_first=1 at count 7 -> err_count=2; the following 16 bits yield the correct new word.
- Reset mid-word: drop rst_n after 9 beats -> m_valid=0 and err_count=0 immediately; next full word 0xFFFF (all-zero serial) is received correctly.
- MSB_FIRST=1, 100 random words with continuous m_ready=1 -> all words match the transmitted ones, m_valid period exactly 16 cycles; also drive 300 bad first-beats -> err_count saturates at 255.
